// File: rtl/rd_pipe_tracker.sv
// Destination-register tracker for the EX/MEM/WB stages with load-use hazard detection.
// Optional saturating load-use stall counter enabled by defining HAZARD_CNT_EN.
module rd_pipe_tracker #(
  parameter int REG_W    = 7,
  parameter int LOAD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_wr_en,
  input  logic             id_is_load,
  input  logic [REG_W-1:0] rs1_d,
  input  logic [REG_W-1:0] rs2_d,
  input  logic             flush,
  input  logic             hold,
  output logic [REG_W-1:0] rd_EX,
  output logic [REG_W-1:0] rd_MEM,
  output logic [REG_W-1:0] rd_WB,
  output logic             stall_id,
  output logic [15:0]      stall_cnt
);

  logic             r_exValid, r_exWr, r_exLoad;
  logic [REG_W-1:0] r_exRd;
  logic             r_memValid, r_memWr, r_memLoad;
  logic [REG_W-1:0] r_memRd;
  // The load flag is never consulted once an instruction reaches WB, so it is not kept there.
  logic             r_wbValid, r_wbWr;
  logic [REG_W-1:0] r_wbRd;

  logic [REG_W-1:0] w_exLoadRd;
  logic [REG_W-1:0] w_memLoadRd;
  logic             w_hit1, w_hit2, w_hazard, w_accept;

  assign rd_EX  = (r_exValid  && r_exWr)  ? r_exRd  : '0;
  assign rd_MEM = (r_memValid && r_memWr) ? r_memRd : '0;
  assign rd_WB  = (r_wbValid  && r_wbWr)  ? r_wbRd  : '0;

  // A non-zero source can never match the zero produced by a non-load or non-writing entry.
  assign w_exLoadRd  = (r_exValid && r_exLoad) ? rd_EX : '0;
  assign w_memLoadRd = (LOAD_LAT == 2 && r_memValid && r_memLoad) ? rd_MEM : '0;

  assign w_hit1   = (rs1_d != '0) && ((rs1_d == w_exLoadRd) || (rs1_d == w_memLoadRd));
  assign w_hit2   = (rs2_d != '0) && ((rs2_d == w_exLoadRd) || (rs2_d == w_memLoadRd));
  assign w_hazard = id_valid && (w_hit1 || w_hit2);

  // Flush only takes effect on advancing edges, so it cannot mask a hazard during hold.
  assign stall_id = w_hazard && (hold || !flush);
  assign w_accept = !stall_id && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exValid  <= 1'b0;
      r_exWr     <= 1'b0;
      r_exLoad   <= 1'b0;
      r_exRd     <= '0;
      r_memValid <= 1'b0;
      r_memWr    <= 1'b0;
      r_memLoad  <= 1'b0;
      r_memRd    <= '0;
      r_wbValid  <= 1'b0;
      r_wbWr     <= 1'b0;
      r_wbRd     <= '0;
    end else if (!hold) begin
      r_wbValid  <= r_memValid;
      r_wbWr     <= r_memWr;
      r_wbRd     <= r_memRd;
      r_memValid <= r_exValid;
      r_memWr    <= r_exWr;
      r_memLoad  <= r_exLoad;
      r_memRd    <= r_exRd;
      r_exValid  <= w_accept && id_valid;
      r_exWr     <= w_accept && id_wr_en;
      r_exLoad   <= w_accept && id_is_load;
      r_exRd     <= w_accept ? id_rd : '0;
    end
  end

`ifdef HAZARD_CNT_EN
  logic [15:0] r_stallCnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stallCnt <= 16'h0000;
    end else if (stall_id && !hold && (r_stallCnt != 16'hFFFF)) begin
      r_stallCnt <= r_stallCnt + 16'd1;
    end
  end

  assign stall_cnt = r_stallCnt;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_rd_pipe_tracker.sv
// Scoreboard bench for rd_pipe_tracker: per-cycle expectations are queued with the stimulus
// and popped as the DUT responds. Counter expectations follow HAZARD_CNT_EN.
module tb_rd_pipe_tracker;
  localparam int REG_W    = 7;
  localparam int LOAD_LAT = 1;
`ifdef HAZARD_CNT_EN
  localparam int CNT_EN = 1;
`else
  localparam int CNT_EN = 0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             id_valid, id_wr_en, id_is_load, flush, hold;
  logic [REG_W-1:0] id_rd, rs1_d, rs2_d;
  logic [REG_W-1:0] rd_EX, rd_MEM, rd_WB;
  logic             stall_id;
  logic [15:0]      stall_cnt;

  typedef struct packed {
    logic             valid, wr, load;
    logic [REG_W-1:0] rd, rs1, rs2;
    logic             flush, hold;
  } stim_t;

  typedef struct packed {
    logic [REG_W-1:0] ex, mem, wb;
    logic             stall;
  } exp_t;

  stim_t st[$];
  exp_t  sb[$];
  int    checks = 0;
  int    failures = 0;

  rd_pipe_tracker #(.REG_W(REG_W), .LOAD_LAT(LOAD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rd(id_rd), .id_wr_en(id_wr_en),
    .id_is_load(id_is_load), .rs1_d(rs1_d), .rs2_d(rs2_d), .flush(flush), .hold(hold),
    .rd_EX(rd_EX), .rd_MEM(rd_MEM), .rd_WB(rd_WB), .stall_id(stall_id), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic stim_t mk(input logic v, input logic w, input logic l, input int rd,
                               input int r1, input int r2, input logic f, input logic h);
    stim_t s;
    s.valid = v; s.wr = w; s.load = l;
    s.rd = REG_W'(rd); s.rs1 = REG_W'(r1); s.rs2 = REG_W'(r2);
    s.flush = f; s.hold = h;
    return s;
  endfunction

  function automatic exp_t ex3(input int e, input int m, input int w, input logic s);
    exp_t x;
    x.ex = REG_W'(e); x.mem = REG_W'(m); x.wb = REG_W'(w); x.stall = s;
    return x;
  endfunction

  task automatic apply(input stim_t s);
    id_valid = s.valid; id_wr_en = s.wr; id_is_load = s.load; id_rd = s.rd;
    rs1_d = s.rs1; rs2_d = s.rs2; flush = s.flush; hold = s.hold;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0));
    repeat (3) tick();
    st.delete();
    sb.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    checks++;
    if ({rd_EX, rd_MEM, rd_WB, stall_id, stall_cnt} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_initial actual=%h/%h/%h/%b/%h expected all zero",
               rd_EX, rd_MEM, rd_WB, stall_id, stall_cnt);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({rd_EX, rd_MEM, rd_WB, stall_id, stall_cnt} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_release actual=%h/%h/%h/%b/%h expected all zero",
               rd_EX, rd_MEM, rd_WB, stall_id, stall_cnt);
    end
  endtask

  task automatic test_alu_chain();
    stim_t s;
    exp_t  e;
    int    i = 0;
    drain();
    st.push_back(mk(1, 1, 0, 5, 0, 0, 0, 0)); sb.push_back(ex3(5, 0, 0, 0));
    st.push_back(mk(1, 1, 0, 6, 5, 0, 0, 0)); sb.push_back(ex3(6, 5, 0, 0));
    st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0)); sb.push_back(ex3(0, 6, 5, 0));
    st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0)); sb.push_back(ex3(0, 0, 6, 0));
    while (st.size() > 0) begin
      s = st.pop_front(); e = sb.pop_front(); apply(s); #1;
      checks++;
      if (stall_id !== e.stall) begin
        failures++;
        $display("[TB] FAIL alu_chain_stall step%0d actual=%b expected=%b", i, stall_id, e.stall);
      end
      tick();
      checks++;
      if ({rd_EX, rd_MEM, rd_WB} !== {e.ex, e.mem, e.wb}) begin
        failures++;
        $display("[TB] FAIL alu_chain_rd step%0d actual=%0d/%0d/%0d expected=%0d/%0d/%0d",
                 i, rd_EX, rd_MEM, rd_WB, e.ex, e.mem, e.wb);
      end
      i++;
    end
  endtask

  task automatic test_load_use();
    stim_t s;
    exp_t  e;
    int    i = 0;
    drain();
    st.push_back(mk(1, 1, 1, 9, 0, 0, 0, 0));  sb.push_back(ex3(9, 0, 0, 0));
    st.push_back(mk(1, 1, 0, 10, 0, 9, 0, 0)); sb.push_back(ex3(0, 9, 0, 1));
    if (LOAD_LAT == 2) begin
      st.push_back(mk(1, 1, 0, 10, 0, 9, 0, 0)); sb.push_back(ex3(0, 0, 9, 1));
      st.push_back(mk(1, 1, 0, 10, 0, 9, 0, 0)); sb.push_back(ex3(10, 0, 0, 0));
    end else begin
      st.push_back(mk(1, 1, 0, 10, 0, 9, 0, 0)); sb.push_back(ex3(10, 0, 9, 0));
    end
    st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0)); sb.push_back(ex3(0, 10, 0, 0));
    while (st.size() > 0) begin
      s = st.pop_front(); e = sb.pop_front(); apply(s); #1;
      checks++;
      if (stall_id !== e.stall) begin
        failures++;
        $display("[TB] FAIL load_use_stall step%0d actual=%b expected=%b", i, stall_id, e.stall);
      end
      tick();
      checks++;
      if ({rd_EX, rd_MEM, rd_WB} !== {e.ex, e.mem, e.wb}) begin
        failures++;
        $display("[TB] FAIL load_use_rd step%0d actual=%0d/%0d/%0d expected=%0d/%0d/%0d",
                 i, rd_EX, rd_MEM, rd_WB, e.ex, e.mem, e.wb);
      end
      i++;
    end
    checks++;
    if (stall_cnt !== 16'(CNT_EN * LOAD_LAT)) begin
      failures++;
      $display("[TB] FAIL load_use_cnt actual=%0d expected=%0d", stall_cnt, CNT_EN * LOAD_LAT);
    end
  endtask

  task automatic test_zero_reg();
    stim_t s;
    exp_t  e;
    int    i = 0;
    drain();
    st.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0));  sb.push_back(ex3(0, 0, 0, 0));
    st.push_back(mk(1, 1, 0, 4, 0, 0, 0, 0));  sb.push_back(ex3(4, 0, 0, 0));
    st.push_back(mk(1, 0, 1, 8, 0, 0, 0, 0));  sb.push_back(ex3(0, 4, 0, 0));
    st.push_back(mk(1, 1, 0, 11, 8, 0, 0, 0)); sb.push_back(ex3(11, 0, 4, 0));
    while (st.size() > 0) begin
      s = st.pop_front(); e = sb.pop_front(); apply(s); #1;
      checks++;
      if (stall_id !== e.stall) begin
        failures++;
        $display("[TB] FAIL zero_reg_stall step%0d actual=%b expected=%b", i, stall_id, e.stall);
      end
      tick();
      checks++;
      if ({rd_EX, rd_MEM, rd_WB} !== {e.ex, e.mem, e.wb}) begin
        failures++;
        $display("[TB] FAIL zero_reg_rd step%0d actual=%0d/%0d/%0d expected=%0d/%0d/%0d",
                 i, rd_EX, rd_MEM, rd_WB, e.ex, e.mem, e.wb);
      end
      i++;
    end
  endtask

  task automatic test_flush_hazard();
    stim_t s;
    exp_t  e;
    int    i = 0;
    drain();
    st.push_back(mk(1, 1, 1, 3, 0, 0, 0, 0));  sb.push_back(ex3(3, 0, 0, 0));
    st.push_back(mk(1, 1, 0, 12, 3, 0, 1, 0)); sb.push_back(ex3(0, 3, 0, 0));
    st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));  sb.push_back(ex3(0, 0, 3, 0));
    st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));  sb.push_back(ex3(0, 0, 0, 0));
    while (st.size() > 0) begin
      s = st.pop_front(); e = sb.pop_front(); apply(s); #1;
      checks++;
      if (stall_id !== e.stall) begin
        failures++;
        $display("[TB] FAIL flush_stall step%0d actual=%b expected=%b", i, stall_id, e.stall);
      end
      tick();
      checks++;
      if ({rd_EX, rd_MEM, rd_WB} !== {e.ex, e.mem, e.wb}) begin
        failures++;
        $display("[TB] FAIL flush_rd step%0d actual=%0d/%0d/%0d expected=%0d/%0d/%0d",
                 i, rd_EX, rd_MEM, rd_WB, e.ex, e.mem, e.wb);
      end
      i++;
    end
  endtask

  task automatic test_hold();
    stim_t s;
    exp_t  e;
    int    i = 0;
    drain();
    st.push_back(mk(1, 1, 0, 5, 0, 0, 0, 0)); sb.push_back(ex3(5, 0, 0, 0));
    st.push_back(mk(1, 1, 0, 6, 0, 0, 0, 0)); sb.push_back(ex3(6, 5, 0, 0));
    st.push_back(mk(1, 1, 1, 7, 0, 0, 0, 0)); sb.push_back(ex3(7, 6, 5, 0));
    for (int k = 0; k < 4; k++) begin
      st.push_back(mk(1, 1, 0, 13, 7, 0, 0, 1)); sb.push_back(ex3(7, 6, 5, 1));
    end
    st.push_back(mk(1, 1, 0, 13, 0, 0, 0, 0)); sb.push_back(ex3(13, 7, 6, 0));
    st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));  sb.push_back(ex3(0, 13, 7, 0));
    while (st.size() > 0) begin
      s = st.pop_front(); e = sb.pop_front(); apply(s); #1;
      checks++;
      if (stall_id !== e.stall) begin
        failures++;
        $display("[TB] FAIL hold_stall step%0d actual=%b expected=%b", i, stall_id, e.stall);
      end
      tick();
      checks++;
      if ({rd_EX, rd_MEM, rd_WB} !== {e.ex, e.mem, e.wb}) begin
        failures++;
        $display("[TB] FAIL hold_rd step%0d actual=%0d/%0d/%0d expected=%0d/%0d/%0d",
                 i, rd_EX, rd_MEM, rd_WB, e.ex, e.mem, e.wb);
      end
      i++;
    end
    checks++;
    if (stall_cnt !== 16'(CNT_EN * LOAD_LAT)) begin
      failures++;
      $display("[TB] FAIL hold_cnt actual=%0d expected=%0d", stall_cnt, CNT_EN * LOAD_LAT);
    end
  endtask

  task automatic test_mid_reset();
    drain();
    apply(mk(1, 1, 0, 1, 0, 0, 0, 0)); tick();
    apply(mk(1, 1, 0, 2, 0, 0, 0, 0)); tick();
    apply(mk(1, 1, 1, 3, 0, 0, 0, 0)); tick();
    apply(mk(1, 1, 0, 4, 3, 0, 0, 0)); #1;
    checks++;
    if ({rd_EX, rd_MEM, rd_WB, stall_id} !== {REG_W'(3), REG_W'(2), REG_W'(1), 1'b1}) begin
      failures++;
      $display("[TB] FAIL mid_reset_pre actual=%0d/%0d/%0d/%b expected=3/2/1/1",
               rd_EX, rd_MEM, rd_WB, stall_id);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rd_EX, rd_MEM, rd_WB, stall_id, stall_cnt} !== '0) begin
      failures++;
      $display("[TB] FAIL mid_reset_async actual=%h/%h/%h/%b/%h expected all zero",
               rd_EX, rd_MEM, rd_WB, stall_id, stall_cnt);
    end
    tick();
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    tick();
    checks++;
    if ({rd_EX, rd_MEM, rd_WB, stall_id, stall_cnt} !== '0) begin
      failures++;
      $display("[TB] FAIL mid_reset_after actual=%h/%h/%h/%b/%h expected all zero",
               rd_EX, rd_MEM, rd_WB, stall_id, stall_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_alu_chain();
    test_load_use();
    test_zero_reg();
    test_flush_hazard();
    test_hold();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rd_pipe_tracker.md
Name: rd_pipe_tracker

Overview:
- Producer side of the operand-forwarding interface: tracks each in-flight instruction's destination register through the EX, MEM and WB stages.
- Drives the rd_EX / rd_MEM / rd_WB fields consumed by the forwarding select logic.
- Detects load-use hazards against the decode-stage sources and asserts a decode stall while inserting bubbles.
- Sits between the decode stage and the forwarding unit.

Parameters:
- REG_W, 7: register specifier width; value 0 means "no register / no forward".
- LOAD_LAT, 1: bubbles required after a load before a dependent instruction may issue; legal values are 1 and 2.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- id_valid  input  1  decode stage holds a real instruction.
- id_rd  input  REG_W  decode-stage destination register.
- id_wr_en  input  1  decode instruction writes id_rd.
- id_is_load  input  1  decode instruction is a load.
- rs1_d  input  REG_W  decode source 1.
- rs2_d  input  REG_W  decode source 2.
- flush  input  1  kill the instruction currently in decode (branch redirect).
- hold  input  1  global pipeline freeze (memory wait).
- rd_EX  output  REG_W  EX-stage destination; 0 if bubble or no write.
- rd_MEM  output  REG_W  MEM-stage destination; 0 if bubble or no write.
- rd_WB  output  REG_W  WB-stage destination; 0 if bubble or no write.
- stall_id  output  1  decode must hold its instruction this cycle.
- stall_cnt  output  16  load-use stall cycle counter (see Optional Feature).

Behaviour:
- Interface decision: one clock, clk; reset rst_n, asynchronous, active-low.
- State: three stage entries (EX, MEM, WB), each holding {valid, wr, load, rd}.
- Reset: all entries invalid; rd_EX = rd_MEM = rd_WB = 0; stall_id = 0; stall_cnt = 0. Reset mid-operation discards all in-flight entries immediately.
- Outputs: rd_X = rd only when entry valid && wr && rd != 0, otherwise 0. Outputs are direct register outputs with no combinational path from inputs.
- Hazard (combinational): id_valid && source != 0, where source is rs1_d or rs2_d.
  - For any LOAD_LAT: hazard when the source equals rd_EX and the EX entry is a load.
  - LOAD_LAT = 2 only: hazard also when the source equals rd_MEM and the MEM entry is a load.
- stall_id = hazard && !flush.
- Each rising edge with hold = 0:
  - WB <- MEM; MEM <- EX.
  - EX <- {id_valid, id_wr_en, id_is_load, id_rd} when !stall_id && !flush; otherwise EX <- bubble.
- hold = 1:
  - All entries frozen; outputs unchanged.
  - stall_id still reflects hazard; flush is ignored (upstream must keep flush asserted until hold drops).
- Simultaneous flush and hazard: flush wins; bubble inserted; stall_id = 0.
- Latency:
  - Decode instruction appears on rd_EX 1 cycle after acceptance, rd_MEM after 2, rd_WB after 3.
  - Load followed by dependent instruction: stall_id high for exactly LOAD_LAT cycles (excluding hold cycles).
- Instruction with id_wr_en = 0 or id_rd = 0 propagates as valid but produces 0 on the rd outputs and never causes a hazard.

Optional Feature:
- Macro: HAZARD_CNT_EN.
- Defined: stall_cnt increments by 1 on each edge where stall_id = 1 && hold = 0. It saturates at 16'hFFFF (no wrap) and is cleared by rst_n only.
- Undefined: stall_cnt is tied to 16'h0000 and no counter flops are built.

Test Plan:
- Reset: assert rst_n = 0 mid-stream with EX/MEM/WB populated -> all rd outputs, stall_id and stall_cnt read 0 immediately, without waiting for a clk edge.
- ALU chain: issue id_rd = 5 (wr) then rs1_d = 5 on the next instruction -> rd_EX = 5 on cycle 1; rd_MEM = 5 on cycle 2; rd_WB = 5 on cycle 3; stall_id stays 0.
- Load-use: load id_rd = 9, then rs2_d = 9 -> stall_id = 1 for 1 cycle (LOAD_LAT = 1) or 2 cycles (LOAD_LAT = 2); bubble shows rd_EX = 0; stall_cnt = 1 or 2 with HAZARD_CNT_EN defined, 0 without.
- Zero register: load id_rd = 0, then rs1_d = 0 -> no stall; rd_EX = 0.
- Flush with hazard: load rd = 3, then a dependent instruction with flush = 1 in the same cycle -> stall_id = 0; next rd_EX = 0; dependent instruction never appears.
- Hold: assert hold for 4 cycles while rd_EX = 7, rd_MEM = 6, rd_WB = 5 -> values unchanged for all 4 cycles, then resume shifting one stage per cycle.
